// File: rtl/decode_if.sv
// Bundle of the decode stage's pipeline-facing signals: the fetch/writeback/MEM
// inputs and the hazard, redirect and ID/EX register outputs.
interface decode_if;
  logic [19:0] instruction_decode;
  logic [15:0] pc_decode;
  logic        wb_reg_write;
  logic [3:0]  wb_rd;
  logic [15:0] wb_data;
  logic        mem_reg_write;
  logic [3:0]  mem_rd;
  logic [1:0]  stall;
  logic [1:0]  flush;
  logic [1:0]  select_pc_mux;
  logic [15:0] branch_address;
  logic        ex_valid;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [3:0]  ex_opcode;
  logic [3:0]  ex_rd;
  logic [15:0] ex_op_a;
  logic [15:0] ex_op_b;
  logic [15:0] ex_store_data;
  logic [15:0] ex_pc;

  // Upstream side: drives the instruction, writeback and MEM information.
  modport master (
    output instruction_decode, pc_decode, wb_reg_write, wb_rd, wb_data,
           mem_reg_write, mem_rd,
    input  stall, flush, select_pc_mux, branch_address,
           ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_opcode, ex_rd,
           ex_op_a, ex_op_b, ex_store_data, ex_pc
  );

  // Decode stage side.
  modport slave (
    input  instruction_decode, pc_decode, wb_reg_write, wb_rd, wb_data,
           mem_reg_write, mem_rd,
    output stall, flush, select_pc_mux, branch_address,
           ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_opcode, ex_rd,
           ex_op_a, ex_op_b, ex_store_data, ex_pc
  );
endinterface

// File: rtl/decode_stage.sv
// Instruction decode: register file with writeback bypass, load-use and branch
// operand hazard detection, BEQ/JMP resolution and the ID/EX pipeline register.
module decode_stage (
  input logic    clk,
  input logic    reset,
  decode_if.slave bus
);
  localparam int DATA_WIDTH  = 16;
  localparam int INSTR_WIDTH = 20;
  localparam int NUM_REGS    = 16;

  logic [INSTR_WIDTH-1:0] instr;
  logic [3:0]             op, rd, rs1, rs2;
  logic [DATA_WIDTH-1:0]  simm8, simm12;

  assign instr  = bus.instruction_decode;
  assign op     = instr[19:16];
  assign rd     = instr[15:12];
  assign rs1    = instr[11:8];
  assign rs2    = instr[7:4];
  assign simm8  = {{8{instr[7]}}, instr[7:0]};
  assign simm12 = {{4{instr[11]}}, instr[11:0]};

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (bus.wb_reg_write && bus.wb_rd != 4'd0) begin
      regs_q[bus.wb_rd] <= bus.wb_data;
    end
  end

  // Three read ports (rs1, rs2, rd); a same-cycle writeback wins over the array.
  logic [3:0]            raddr [3];
  logic [DATA_WIDTH-1:0] rdata [3];
  assign raddr[0] = rs1;
  assign raddr[1] = rs2;
  assign raddr[2] = rd;

  for (genvar gi = 0; gi < 3; gi++) begin : g_rport
    always_comb begin
      rdata[gi] = regs_q[raddr[gi]];
      if (raddr[gi] == 4'd0)
        rdata[gi] = '0;
      else if (bus.wb_reg_write && bus.wb_rd == raddr[gi])
        rdata[gi] = bus.wb_data;
    end
  end

  logic use_rs1, use_rs2, use_rd, is_beq, is_jmp, is_issue;
  always_comb begin
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    use_rd   = 1'b0;
    is_beq   = 1'b0;
    is_jmp   = 1'b0;
    is_issue = 1'b0;
    case (op)
      4'd1, 4'd2, 4'd3, 4'd4: begin use_rs1 = 1'b1; use_rs2 = 1'b1; is_issue = 1'b1; end
      4'd5, 4'd6:             begin use_rs1 = 1'b1; is_issue = 1'b1; end
      4'd7:                   begin use_rs1 = 1'b1; use_rd = 1'b1; is_issue = 1'b1; end
      4'd8:                   begin use_rs1 = 1'b1; use_rd = 1'b1; is_beq = 1'b1; end
      4'd9:                   is_jmp = 1'b1;
      default: ;
    endcase
  end

  logic                  ex_valid_q, ex_reg_write_q, ex_mem_read_q, ex_mem_write_q;
  logic [3:0]            ex_opcode_q, ex_rd_q;
  logic [DATA_WIDTH-1:0] ex_op_a_q, ex_op_b_q, ex_store_data_q, ex_pc_q;

  logic load_use, br_hazard, hazard, taken, redirect;
  logic ex_fwd_ok;
  assign ex_fwd_ok = ex_valid_q && ex_reg_write_q;

  assign load_use = ex_valid_q && ex_mem_read_q && ex_rd_q != 4'd0 &&
                    ((use_rs1 && rs1 == ex_rd_q) || (use_rs2 && rs2 == ex_rd_q) ||
                     (use_rd && rd == ex_rd_q));

  // A BEQ compares in decode, so any in-flight producer of its operands blocks it.
  assign br_hazard = is_beq &&
      ((rs1 != 4'd0 && ((ex_fwd_ok && rs1 == ex_rd_q) || (bus.mem_reg_write && rs1 == bus.mem_rd))) ||
       (rd  != 4'd0 && ((ex_fwd_ok && rd  == ex_rd_q) || (bus.mem_reg_write && rd  == bus.mem_rd))));

  assign hazard   = !reset && (load_use || br_hazard);
  assign taken    = is_beq && (rdata[2] == rdata[0]);
  assign redirect = !reset && !hazard && (is_jmp || taken);

  assign bus.stall         = {1'b0, hazard};
  assign bus.flush         = {1'b0, redirect};
  assign bus.select_pc_mux = {1'b0, redirect};

  always_comb begin
    bus.branch_address = '0;
    if (!reset) begin
      if (is_jmp)      bus.branch_address = bus.pc_decode + simm12;
      else if (is_beq) bus.branch_address = bus.pc_decode + simm8;
    end
  end

  logic                  ex_valid_d, ex_reg_write_d, ex_mem_read_d, ex_mem_write_d;
  logic [3:0]            ex_opcode_d, ex_rd_d;
  logic [DATA_WIDTH-1:0] ex_op_a_d, ex_op_b_d, ex_store_data_d, ex_pc_d;

  // Anything other than an issuing ALU/memory op, or a stalled one, is a bubble.
  always_comb begin
    ex_valid_d      = 1'b0;
    ex_reg_write_d  = 1'b0;
    ex_mem_read_d   = 1'b0;
    ex_mem_write_d  = 1'b0;
    ex_opcode_d     = '0;
    ex_rd_d         = '0;
    ex_op_a_d       = '0;
    ex_op_b_d       = '0;
    ex_store_data_d = '0;
    ex_pc_d         = '0;
    if (is_issue && !hazard) begin
      ex_valid_d      = 1'b1;
      ex_opcode_d     = op;
      ex_rd_d         = rd;
      ex_pc_d         = bus.pc_decode;
      ex_op_a_d       = rdata[0];
      ex_op_b_d       = (op <= 4'd4) ? rdata[1] : simm8;
      ex_reg_write_d  = (op <= 4'd6);
      ex_mem_read_d   = (op == 4'd6);
      ex_mem_write_d  = (op == 4'd7);
      ex_store_data_d = (op == 4'd7) ? rdata[2] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_q      <= 1'b0;
      ex_reg_write_q  <= 1'b0;
      ex_mem_read_q   <= 1'b0;
      ex_mem_write_q  <= 1'b0;
      ex_opcode_q     <= '0;
      ex_rd_q         <= '0;
      ex_op_a_q       <= '0;
      ex_op_b_q       <= '0;
      ex_store_data_q <= '0;
      ex_pc_q         <= '0;
    end else begin
      ex_valid_q      <= ex_valid_d;
      ex_reg_write_q  <= ex_reg_write_d;
      ex_mem_read_q   <= ex_mem_read_d;
      ex_mem_write_q  <= ex_mem_write_d;
      ex_opcode_q     <= ex_opcode_d;
      ex_rd_q         <= ex_rd_d;
      ex_op_a_q       <= ex_op_a_d;
      ex_op_b_q       <= ex_op_b_d;
      ex_store_data_q <= ex_store_data_d;
      ex_pc_q         <= ex_pc_d;
    end
  end

  assign bus.ex_valid      = ex_valid_q;
  assign bus.ex_reg_write  = ex_reg_write_q;
  assign bus.ex_mem_read   = ex_mem_read_q;
  assign bus.ex_mem_write  = ex_mem_write_q;
  assign bus.ex_opcode     = ex_opcode_q;
  assign bus.ex_rd         = ex_rd_q;
  assign bus.ex_op_a       = ex_op_a_q;
  assign bus.ex_op_b       = ex_op_b_q;
  assign bus.ex_store_data = ex_store_data_q;
  assign bus.ex_pc         = ex_pc_q;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: operand reads, bypass, hazards, redirects and
// reset, each scenario checked against hand-computed values.
module tb_decode_stage;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  decode_if bus ();
  decode_stage dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [19:0] instr, input logic [15:0] pc);
    bus.instruction_decode = instr;
    bus.pc_decode = pc;
    #1;
    $display("txn instr=%05h pc=%04h stall=%0d flush=%0d sel=%0d ba=%04h",
             instr, pc, bus.stall, bus.flush, bus.select_pc_mux, bus.branch_address);
  endtask

  task automatic wb(input logic en, input logic [3:0] r, input logic [15:0] d);
    bus.wb_reg_write = en;
    bus.wb_rd = r;
    bus.wb_data = d;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    wb(1'b0, 4'd0, 16'h0);
    bus.mem_reg_write = 1'b0;
    bus.mem_rd = 4'd0;
    drive(20'h9FFF0, 16'h0020);
    tick;
    tick;
    checks++;
    if ({bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_opcode, bus.ex_rd} !== 12'h0)
      begin failures++; $display("FAIL reset_ctrl got=%h want=0", {bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_opcode, bus.ex_rd}); end
    checks++;
    if ({bus.ex_op_a, bus.ex_op_b, bus.ex_store_data, bus.ex_pc} !== 64'h0)
      begin failures++; $display("FAIL reset_data got=%h want=0", {bus.ex_op_a, bus.ex_op_b, bus.ex_store_data, bus.ex_pc}); end
    checks++;
    if ({bus.stall, bus.flush, bus.select_pc_mux, bus.branch_address} !== 22'h0)
      begin failures++; $display("FAIL reset_ctl_out got=%h want=0", {bus.stall, bus.flush, bus.select_pc_mux, bus.branch_address}); end
    reset = 1'b0;
    drive(20'h00000, 16'h0000);
  endtask

  task automatic test_basic_alu;
    wb(1'b1, 4'd3, 16'h1234);
    tick;
    wb(1'b0, 4'd0, 16'h0);
    drive(20'h15330, 16'h0004);
    tick;
    checks++;
    if (bus.ex_op_a !== 16'h1234) begin failures++; $display("FAIL alu_a got=%h want=1234", bus.ex_op_a); end
    checks++;
    if (bus.ex_op_b !== 16'h1234) begin failures++; $display("FAIL alu_b got=%h want=1234", bus.ex_op_b); end
    checks++;
    if ({bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_opcode, bus.ex_rd} !== {4'b1100, 4'd1, 4'd5})
      begin failures++; $display("FAIL alu_ctrl got=%h want=c15", {bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_opcode, bus.ex_rd}); end
    checks++;
    if (bus.ex_pc !== 16'h0004) begin failures++; $display("FAIL alu_pc got=%h want=0004", bus.ex_pc); end
  endtask

  task automatic test_bypass;
    wb(1'b1, 4'd2, 16'h00FF);
    drive(20'h51205, 16'h0008);
    tick;
    checks++;
    if (bus.ex_op_a !== 16'h00FF) begin failures++; $display("FAIL byp_a got=%h want=00ff", bus.ex_op_a); end
    checks++;
    if (bus.ex_op_b !== 16'h0005) begin failures++; $display("FAIL byp_imm got=%h want=0005", bus.ex_op_b); end
    wb(1'b1, 4'd0, 16'hAAAA);
    drive(20'h10000, 16'h000A);
    tick;
    checks++;
    if (bus.ex_op_a !== 16'h0000) begin failures++; $display("FAIL r0_bypass got=%h want=0000", bus.ex_op_a); end
    wb(1'b0, 4'd0, 16'h0);
    drive(20'h10000, 16'h000C);
    tick;
    checks++;
    if (bus.ex_op_a !== 16'h0000) begin failures++; $display("FAIL r0_write got=%h want=0000", bus.ex_op_a); end
    drive(20'h10220, 16'h000E);
    tick;
    checks++;
    if ({bus.ex_op_a, bus.ex_op_b} !== {16'h00FF, 16'h00FF})
      begin failures++; $display("FAIL r2_kept got=%h want=00ff00ff", {bus.ex_op_a, bus.ex_op_b}); end
  endtask

  task automatic test_load_use;
    drive(20'h64100, 16'h0010);
    tick;
    checks++;
    if ({bus.ex_mem_read, bus.ex_reg_write, bus.ex_rd} !== {2'b11, 4'd4})
      begin failures++; $display("FAIL load_ctrl got=%h want=34", {bus.ex_mem_read, bus.ex_reg_write, bus.ex_rd}); end
    drive(20'h16410, 16'h0012);
    checks++;
    if ({bus.stall, bus.flush, bus.select_pc_mux} !== 6'b010000)
      begin failures++; $display("FAIL lu_stall got=%b want=010000", {bus.stall, bus.flush, bus.select_pc_mux}); end
    tick;
    checks++;
    if (bus.ex_valid !== 1'b0) begin failures++; $display("FAIL lu_bubble got=%b want=0", bus.ex_valid); end
    checks++;
    if (bus.stall !== 2'b00) begin failures++; $display("FAIL lu_one_cycle got=%b want=00", bus.stall); end
    tick;
    checks++;
    if ({bus.ex_valid, bus.ex_opcode, bus.ex_rd} !== {1'b1, 4'd1, 4'd6})
      begin failures++; $display("FAIL lu_issue got=%h want=116", {bus.ex_valid, bus.ex_opcode, bus.ex_rd}); end
  endtask

  task automatic test_branch;
    wb(1'b1, 4'd1, 16'h0007);
    drive(20'h00000, 16'h0000);
    tick;
    wb(1'b1, 4'd2, 16'h0007);
    tick;
    wb(1'b0, 4'd0, 16'h0);
    drive(20'h812FC, 16'h0010);
    checks++;
    if (bus.branch_address !== 16'h000C) begin failures++; $display("FAIL beq_target got=%h want=000c", bus.branch_address); end
    checks++;
    if ({bus.stall, bus.flush, bus.select_pc_mux} !== 6'b000101)
      begin failures++; $display("FAIL beq_taken got=%b want=000101", {bus.stall, bus.flush, bus.select_pc_mux}); end
    tick;
    checks++;
    if (bus.ex_valid !== 1'b0) begin failures++; $display("FAIL beq_bubble got=%b want=0", bus.ex_valid); end
    wb(1'b1, 4'd2, 16'h0008);
    drive(20'h00000, 16'h0000);
    tick;
    wb(1'b0, 4'd0, 16'h0);
    drive(20'h812FC, 16'h0010);
    checks++;
    if ({bus.stall, bus.flush, bus.select_pc_mux} !== 6'b000000)
      begin failures++; $display("FAIL beq_not_taken got=%b want=000000", {bus.stall, bus.flush, bus.select_pc_mux}); end
    checks++;
    if (bus.branch_address !== 16'h000C) begin failures++; $display("FAIL beq_nt_target got=%h want=000c", bus.branch_address); end
    tick;
  endtask

  task automatic test_jump_and_hazard;
    drive(20'h9FFF0, 16'h0020);
    checks++;
    if ({bus.branch_address, bus.flush, bus.select_pc_mux} !== {16'h0010, 4'b0101})
      begin failures++; $display("FAIL jmp got=%h want=00105", {bus.branch_address, bus.flush, bus.select_pc_mux}); end
    drive(20'h9FFF0, 16'h0002);
    checks++;
    if (bus.branch_address !== 16'hFFF2) begin failures++; $display("FAIL jmp_wrap_low got=%h want=fff2", bus.branch_address); end
    drive(20'h90004, 16'hFFFE);
    checks++;
    if (bus.branch_address !== 16'h0002) begin failures++; $display("FAIL jmp_wrap_high got=%h want=0002", bus.branch_address); end
    tick;
    checks++;
    if (bus.ex_valid !== 1'b0) begin failures++; $display("FAIL jmp_bubble got=%b want=0", bus.ex_valid); end
    bus.mem_reg_write = 1'b1;
    bus.mem_rd = 4'd1;
    drive(20'h812FC, 16'h0010);
    checks++;
    if ({bus.stall, bus.flush, bus.select_pc_mux} !== 6'b010000)
      begin failures++; $display("FAIL beq_mem_hazard got=%b want=010000", {bus.stall, bus.flush, bus.select_pc_mux}); end
    tick;
    checks++;
    if (bus.ex_valid !== 1'b0) begin failures++; $display("FAIL beq_mem_bubble got=%b want=0", bus.ex_valid); end
    bus.mem_rd = 4'd0;
    drive(20'h800FC, 16'h0040);
    checks++;
    if ({bus.stall, bus.flush, bus.select_pc_mux} !== 6'b000101)
      begin failures++; $display("FAIL beq_r0_no_hazard got=%b want=000101", {bus.stall, bus.flush, bus.select_pc_mux}); end
    bus.mem_reg_write = 1'b0;
    drive(20'h51100, 16'h0014);
    tick;
    drive(20'h812FC, 16'h0016);
    checks++;
    if ({bus.stall, bus.select_pc_mux} !== 4'b0100)
      begin failures++; $display("FAIL beq_ex_hazard got=%b want=0100", {bus.stall, bus.select_pc_mux}); end
    tick;
    checks++;
    if ({bus.stall, bus.select_pc_mux} !== 4'b0000)
      begin failures++; $display("FAIL beq_ex_resolved got=%b want=0000", {bus.stall, bus.select_pc_mux}); end
  endtask

  task automatic test_reset_mid_stall;
    drive(20'h64100, 16'h0030);
    tick;
    drive(20'h16410, 16'h0032);
    checks++;
    if (bus.stall !== 2'b01) begin failures++; $display("FAIL pre_reset_stall got=%b want=01", bus.stall); end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.stall !== 2'b00) begin failures++; $display("FAIL reset_drops_stall got=%b want=00", bus.stall); end
    tick;
    checks++;
    if ({bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_opcode, bus.ex_rd,
         bus.ex_op_a, bus.ex_op_b, bus.ex_store_data, bus.ex_pc} !== 76'h0)
      begin failures++; $display("FAIL mid_reset_ex got=%h want=0", {bus.ex_valid, bus.ex_opcode, bus.ex_rd, bus.ex_op_a, bus.ex_pc}); end
    checks++;
    if ({bus.stall, bus.flush, bus.select_pc_mux, bus.branch_address} !== 22'h0)
      begin failures++; $display("FAIL mid_reset_ctl got=%h want=0", {bus.stall, bus.flush, bus.select_pc_mux, bus.branch_address}); end
    reset = 1'b0;
    drive(20'h10120, 16'h0034);
    checks++;
    if (bus.stall !== 2'b00) begin failures++; $display("FAIL post_reset_stall got=%b want=00", bus.stall); end
    tick;
    checks++;
    if ({bus.ex_valid, bus.ex_op_a, bus.ex_op_b} !== {1'b1, 32'h0})
      begin failures++; $display("FAIL regs_cleared got=%h want=100000000", {bus.ex_valid, bus.ex_op_a, bus.ex_op_b}); end
    wb(1'b1, 4'd5, 16'h0055);
    drive(20'h00000, 16'h0036);
    tick;
    wb(1'b0, 4'd0, 16'h0);
    drive(20'h17500, 16'h0038);
    tick;
    checks++;
    if ({bus.ex_op_a, bus.ex_rd} !== {16'h0055, 4'd7})
      begin failures++; $display("FAIL resume got=%h want=00557", {bus.ex_op_a, bus.ex_rd}); end
  endtask

  initial begin
    test_reset;
    test_basic_alu;
    test_bypass;
    test_load_use;
    test_branch;
    test_jump_and_hazard;
    test_reset_mid_stall;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
